// File: rtl/tryte_to_bin_seq.sv
// tryte_to_bin_seq
//   Serial balanced-ternary to two's-complement converter. One word of TRITS
//   trits is accepted, then folded most-significant trit first (acc = 3*acc + t),
//   one trit per clock. The result is held in DONE until the consumer takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_tryte holds a word to convert
//   in_ready   block accepts a word this cycle (IDLE only)
//   in_tryte   trit k at [2k+1:2k]; 11=-1, 00=0, 01=+1, 10=invalid
//   out_valid  out_value/out_err hold a result (DONE only)
//   out_ready  consumer takes the result this cycle
//   out_value  signed integer sum(trit_k * 3^k); 0 when out_err
//   out_err    some input trit was the invalid code 2'b10
module tryte_to_bin_seq #(
    parameter int TRITS = 9,
    parameter int OUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*TRITS-1:0]   in_tryte,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_value,
    output logic                 out_err
);

    // Bits needed for +/-(3^t-1)/2 including the sign bit.
    function automatic int need_bits(input int t);
        longint m;
        int     b;
        m = 1;
        for (int i = 0; i < t; i++) m = m * 3;
        m = (m - 1) / 2;
        b = 1;
        while (((64'sd1 <<< (b - 1)) - 1) < m) b++;
        return b;
    endfunction

    localparam int NEED = need_bits(TRITS);
    localparam int CW   = $clog2(TRITS + 1);

    generate
        if (OUT_W < NEED) begin : g_width_chk
            $error("tryte_to_bin_seq: OUT_W too small for TRITS");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t                   state, state_nx;
    logic [2*TRITS-1:0]       sr;
    logic signed [OUT_W-1:0]  acc;
    logic                     err;
    logic [CW-1:0]            cnt;

    logic [1:0]               msb;
    logic signed [OUT_W-1:0]  trit_v;
    logic signed [OUT_W-1:0]  acc_nx;
    logic                     err_nx;
    logic                     last;

    assign msb      = sr[2*TRITS-1 -: 2];
    assign last     = (cnt == CW'(1));
    assign in_ready = (state == IDLE);
    assign out_valid = (state == DONE);

    // Invalid code contributes 0; it only raises the error flag.
    always_comb begin
        trit_v = '0;
        case (msb)
            2'b01:   trit_v = OUT_W'(1);
            2'b11:   trit_v = '1;
            default: trit_v = '0;
        endcase
    end

    assign acc_nx = (acc <<< 1) + acc + trit_v;
    assign err_nx = err | (msb == 2'b10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = CONV;
            CONV:    if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            acc       <= '0;
            err       <= 1'b0;
            cnt       <= '0;
            out_value <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sr  <= in_tryte;
                    acc <= '0;
                    err <= 1'b0;
                    cnt <= CW'(TRITS);
                end
                CONV: begin
                    acc <= acc_nx;
                    err <= err_nx;
                    sr  <= sr << 2;
                    cnt <= cnt - CW'(1);
                    // Result registers only move on the final trit, so they
                    // hold through DONE and the following IDLE.
                    if (last) begin
                        out_value <= err_nx ? '0 : acc_nx;
                        out_err   <= err_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tryte_to_bin_seq.sv
module tb_tryte_to_bin_seq;

    localparam int TRITS = 9;
    localparam int OUT_W = 16;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [2*TRITS-1:0]  in_tryte;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_value;
    logic                out_err;

    int ncmp  = 0;
    int nfail = 0;

    tryte_to_bin_seq #(.TRITS(TRITS), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tryte  (in_tryte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: direct sum of trit_k * 3^k, error if any code is 2'b10.
    task automatic ref_conv(input logic [2*TRITS-1:0] w, output int v, output bit e);
        int p;
        logic [1:0] t;
        v = 0; e = 1'b0; p = 1;
        for (int k = 0; k < TRITS; k++) begin
            t = w[2*k +: 2];
            if (t == 2'b01) v = v + p;
            else if (t == 2'b11) v = v - p;
            else if (t == 2'b10) e = 1'b1;
            p = p * 3;
        end
        if (e) v = 0;
    endtask

    // Integer to balanced-ternary word.
    function automatic logic [2*TRITS-1:0] to_tryte(input int n);
        logic [2*TRITS-1:0] w;
        int r, m;
        w = '0; m = n;
        for (int k = 0; k < TRITS; k++) begin
            r = ((m % 3) + 3) % 3;
            if (r == 0)      begin w[2*k +: 2] = 2'b00; m = m / 3;       end
            else if (r == 1) begin w[2*k +: 2] = 2'b01; m = (m - 1) / 3; end
            else             begin w[2*k +: 2] = 2'b11; m = (m + 1) / 3; end
        end
        return w;
    endfunction

    task automatic accept(input logic [2*TRITS-1:0] w);
        int g;
        in_tryte = w; in_valid = 1'b1; g = 0;
        while (!in_ready && g < 50) begin tick(); g++; end
        check("in_ready_before_accept", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_tryte = 2*TRITS'($urandom);
    endtask

    task automatic wait_out();
        int lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_tryte = 2*TRITS'($urandom);
            tick(); lat++;
        end
        check("latency", lat, TRITS);
    endtask

    task automatic drain(input int ev, input bit ee, input int stall);
        for (int i = 0; i < stall; i++) begin
            check("stall_valid", out_valid, 1);
            check("stall_value", int'($signed(out_value)), ev);
            tick();
        end
        check("out_valid", out_valid, 1);
        check("out_value", int'($signed(out_value)), ev);
        check("out_err", out_err, ee);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_valid", out_valid, 0);
        check("post_hs_ready", in_ready, 1);
        check("post_hs_hold", int'($signed(out_value)), ev);
    endtask

    task automatic run_word(input logic [2*TRITS-1:0] w, input int ev, input bit ee, input int stall);
        accept(w);
        wait_out();
        drain(ev, ee, stall);
    endtask

    initial begin
        int v;
        bit e;
        logic [2*TRITS-1:0] w;
        logic [2*TRITS-1:0] wb;
        int r;

        rst_n = 1'b0; in_valid = 1'b0; in_tryte = '0; out_ready = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_value", out_value, 0);
        check("rst_out_err", out_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed words.
        run_word(18'b010101010101010101,  9841, 1'b0, 0);
        run_word(18'b111111111111111111, -9841, 1'b0, 2);
        check("neg_max_raw", out_value, 16'hD98F);
        run_word(18'b000000000000110011,   -10, 1'b0, 0);
        run_word(18'b000000000000000111,     2, 1'b0, 1);
        run_word(18'b000000000000000000,     0, 1'b0, 0);
        run_word(18'b000000000000001000,     0, 1'b1, 0);
        run_word(18'b100000000000000001,     0, 1'b1, 0);

        // Backpressure with a new word already waiting.
        w  = 18'b010101010101010101;
        wb = to_tryte(-1234);
        accept(w);
        wait_out();
        in_valid = 1'b1; in_tryte = wb;
        for (int i = 0; i < 20; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_value", int'($signed(out_value)), 9841);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ready_after_hs", in_ready, 1);
        tick();
        in_valid = 1'b0;
        wait_out();
        drain(-1234, 1'b0, 0);

        // Reset in the middle of a conversion.
        accept(18'b010101010101010101);
        for (int i = 0; i < 4; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_value", out_value, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("midrst_no_result", out_valid, 0);
        run_word(18'b000000000000000100, 3, 1'b0, 0);

        // Random words, including invalid codes.
        for (int i = 0; i < 150; i++) begin
            for (int k = 0; k < TRITS; k++) begin
                r = int'($urandom_range(0, 24));
                if (r == 0)       w[2*k +: 2] = 2'b10;
                else if (r < 9)   w[2*k +: 2] = 2'b11;
                else if (r < 17)  w[2*k +: 2] = 2'b00;
                else              w[2*k +: 2] = 2'b01;
            end
            ref_conv(w, v, e);
            run_word(w, v, e, int'($urandom_range(0, 4)));
        end

        // Strided sweep of the full range, ends included.
        for (int n = -9841; n <= 9841; n += 13) begin
            w = to_tryte(n);
            ref_conv(w, v, e);
            check("model_vs_int", v, n);
            run_word(w, n, 1'b0, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/tryte_to_bin_seq.md
TRYTE_TO_BIN_SEQ -- requirements
Module: tryte_to_bin_seq

Interface
REQ-001 Parameter TRITS, default 9, SHALL set the number of trits per input word; the input width is 2*TRITS bits.
REQ-002 Parameter OUT_W, default 16, SHALL set the signed output width and SHALL be at least the bits needed for +/-(3^TRITS-1)/2 plus sign; an elaboration-time check SHALL fail otherwise.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 in_valid  input  1  SHALL indicate in_tryte holds a word to convert.
REQ-006 in_ready  output  1  SHALL indicate the block accepts a word this cycle.
REQ-007 in_tryte  input  2*TRITS  SHALL carry the word, trit k at bits [2k+1:2k]; encoding 2'b11=-1, 2'b00=0, 2'b01=+1; 2'b10 is invalid.
REQ-008 out_valid  output  1  SHALL indicate out_value/out_err hold a result.
REQ-009 out_ready  input  1  SHALL indicate the consumer takes the result this cycle.
REQ-010 out_value  output  OUT_W  SHALL be the two's-complement integer equal to sum(trit_k * 3^k).
REQ-011 out_err  output  1  SHALL be 1 when any input trit was 2'b10.

Function
REQ-012 States SHALL be IDLE, CONV, DONE; encoding is free.
REQ-013 In IDLE in_ready SHALL be 1; in CONV and DONE in_ready SHALL be 0.
REQ-014 An accept SHALL occur on a rising edge with in_valid=1 and in_ready=1: latch in_tryte into a shift register, clear accumulator and error flag, load trit counter with TRITS, go to CONV.
REQ-015 Each CONV cycle SHALL process the most significant unprocessed trit: acc <= 3*acc + trit, err <= err | (trit==2'b10), shift register left by 2, counter decrement.
REQ-016 Arithmetic SHALL be signed OUT_W-bit; no intermediate overflow occurs within parameter limits.
REQ-017 The edge processing the last trit SHALL enter DONE; out_valid SHALL rise exactly TRITS cycles after the accept edge (9 for default).
REQ-018 In DONE out_valid SHALL be 1 and out_value/out_err SHALL be stable until the handshake edge (out_valid=1, out_ready=1).
REQ-019 If out_err=1 then out_value SHALL be 0.
REQ-020 On the output handshake edge the block SHALL return to IDLE; in_ready SHALL be 1 the following cycle (no same-cycle accept-while-draining bypass).
REQ-021 Outside DONE out_valid SHALL be 0; out_value/out_err SHALL hold their last values.
REQ-022 in_tryte changes after the accept edge SHALL NOT affect the conversion in progress.
REQ-023 out_ready held 0 indefinitely SHALL keep the block in DONE with no lost or altered result.

Reset
REQ-024 rst_n=0 SHALL immediately, independent of clk, force state IDLE, in_ready=1, out_valid=0, out_value=0, out_err=0, accumulator, counter and shift register to 0.
REQ-025 Reset asserted during CONV or DONE SHALL discard the word in progress; no result SHALL be produced for it.
REQ-026 After rst_n deasserts the first accept SHALL be possible on the first rising edge with in_valid=1.

Verification
REQ-027 in_tryte=18'b010101010101010101, out_ready=1 -> out_valid 9 cycles after accept, out_value=9841, out_err=0.
REQ-028 in_tryte=18'b111111111111111111 -> out_value=-9841 (16'hD98F); in_tryte=18'b000000000000110011 -> -10; 18'b000000000000000111 -> 2; 18'b0 -> 0.
REQ-029 in_tryte=18'b000000000000001000 (trit 1 = 2'b10) -> out_err=1, out_value=0.
REQ-030 Backpressure: out_ready=0 for 20 cycles after out_valid, in_valid held 1 with a new word -> in_ready stays 0, result stable; on out_ready=1 handshake, next word accepted one cycle later and converted correctly.
REQ-031 Reset mid-conversion: rst_n=0 at cycle 4 of CONV -> in_ready=1, out_valid=0 immediately; after release, word 18'b000000000000000100 converts to 3 with no residue of the aborted word.
REQ-032 Exhaustive sweep -9841..9841 back-to-back, random out_ready stalls -> every out_value matches input integer, results in order, none dropped or duplicated.
